// File: rtl/ms_reg_bank.sv
// Word-wide universal register: hold, load, shift and up/down count with a
// registered terminal-count pulse on every wrap.
module ms_reg_bank #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] PRESET_VAL  = '1,
    parameter bit               AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             prs,
    input  logic             ce,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_b,
    output logic             sout,
    output logic             tc
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LOAD  = 2'b01,
        MODE_SHIFT = 2'b10,
        MODE_COUNT = 2'b11
    } mode_e;

    mode_e mode_sel;

    assign mode_sel = mode_e'(mode);

    // clr beats prs, both beat ce; tc is only ever set by a counting wrap
    always_ff @(posedge clk) begin
        if (clr) begin
            q  <= '0;
            tc <= 1'b0;
        end else if (prs) begin
            q  <= PRESET_VAL;
            tc <= 1'b0;
        end else if (!ce) begin
            tc <= 1'b0;
        end else begin
            case (mode_sel)
                MODE_HOLD: begin
                    tc <= 1'b0;
                end
                MODE_LOAD: begin
                    q  <= d;
                    tc <= 1'b0;
                end
                MODE_SHIFT: begin
                    q  <= dir ? {sin, q[WIDTH-1:1]} : {q[WIDTH-2:0], sin};
                    tc <= 1'b0;
                end
                MODE_COUNT: begin
                    if (!dir) begin
                        q  <= q + WIDTH'(1);
                        tc <= &q;
                    end else if (q != '0) begin
                        q  <= q - WIDTH'(1);
                        tc <= 1'b0;
                    end else begin
                        q  <= AUTO_RELOAD ? d : '1;
                        tc <= 1'b1;
                    end
                end
                default: begin
                    tc <= 1'b0;
                end
            endcase
        end
    end

    assign q_b  = ~q;
    assign sout = dir ? q[0] : q[WIDTH-1];

endmodule
